sound_event_sequencer: RTL

- Initiator side of the tone-trigger interface: collects game-sound events (wall hit, paddle hit, score) from game logic and queues them.
- Issues them one at a time to a downstream tone engine as a start pulse plus tone parameters, then waits for the engine's busy/idle handshake.
- Sits between collision/score logic and the speaker tone engine. Flushes all pending sound when the game ends.

---
 rtl/sound_event_sequencer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sound_event_sequencer.sv
// sound_event_sequencer
// Collects game-sound events (wall, paddle, score) into a small FIFO and
// issues them one at a time to a tone engine: a tone_start pulse with the
// tone parameters, then a busy/idle handshake with the engine, then a
// silent gap before the next tone. game_end flushes everything.
//
// Handshake with the tone engine: tone_start is a one-cycle request that
// carries tone_half/tone_dur. The engine acknowledges by raising tone_busy
// within ACK_TIMEOUT cycles and holds it for the whole tone; busy falling
// marks completion. tone_abort is a one-cycle request to stop at once.
//
// Optional build macro: SND_DEDUP_EN. When defined, an event whose code
// equals the most recently pushed entry (while that entry is still queued)
// is discarded without setting overflow.
//
// A full queue drops the selected event based on the occupancy at the
// start of the cycle, even if the head is popped in that same cycle.
module sound_event_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WALL_HALF   = 28409,
    parameter int unsigned PADDLE_HALF = 14204,
    parameter int unsigned SCORE_HALF  = 42613,
    parameter int unsigned WALL_DUR    = 8388607,
    parameter int unsigned PADDLE_DUR  = 4194303,
    parameter int unsigned SCORE_DUR   = 8388607,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned GAP_CYCLES  = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ev_wall,
    input  logic        ev_paddle,
    input  logic        ev_score,
    input  logic        game_end,
    input  logic        tone_busy,
    output logic        tone_start,
    output logic [16:0] tone_half,
    output logic [22:0] tone_dur,
    output logic        tone_abort,
    output logic [4:0]  q_level,
    output logic        overflow,
    output logic        ack_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] CODE_NONE   = 2'd0;
    localparam logic [1:0] CODE_WALL   = 2'd1;
    localparam logic [1:0] CODE_PADDLE = 2'd2;
    localparam logic [1:0] CODE_SCORE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_PLAY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [1:0]        mem_q [FIFO_DEPTH];
    logic [1:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]        count_q, count_d;
    logic              pend_wall_q, pend_wall_d;
    logic              pend_paddle_q, pend_paddle_d;
    logic              pend_score_q, pend_score_d;
    logic              tone_start_q, tone_start_d;
    logic [16:0]       tone_half_q, tone_half_d;
    logic [22:0]       tone_dur_q, tone_dur_d;
    logic              tone_abort_q, tone_abort_d;
    logic              overflow_q, overflow_d;
    logic              ack_err_q, ack_err_d;

    logic              eff_wall, eff_paddle, eff_score;
    logic [1:0]        sel_code;
    logic [1:0]        head_code;
    logic              fifo_full;
    logic              is_dup;
    logic              push;
    logic              drop;
    logic              pop;

    function automatic logic [16:0] half_of(input logic [1:0] code);
        case (code)
            CODE_WALL:   half_of = 17'(WALL_HALF);
            CODE_PADDLE: half_of = 17'(PADDLE_HALF);
            CODE_SCORE:  half_of = 17'(SCORE_HALF);
            default:     half_of = '0;
        endcase
    endfunction

    function automatic logic [22:0] dur_of(input logic [1:0] code);
        case (code)
            CODE_WALL:   dur_of = 23'(WALL_DUR);
            CODE_PADDLE: dur_of = 23'(PADDLE_DUR);
            CODE_SCORE:  dur_of = 23'(SCORE_DUR);
            default:     dur_of = '0;
        endcase
    endfunction

    assign fifo_full = (count_q == 5'(FIFO_DEPTH));
    assign head_code = mem_q[rd_ptr_q];

`ifdef SND_DEDUP_EN
    logic [PTR_W-1:0] last_ptr;
    assign last_ptr = wr_ptr_q - PTR_W'(1);
    assign is_dup   = (count_q != 5'd0) && (mem_q[last_ptr] == sel_code);
`else
    assign is_dup   = 1'b0;
`endif

    // Arbiter: a pulse this cycle counts together with its latch; score wins.
    always_comb begin
        eff_wall   = pend_wall_q   | ev_wall;
        eff_paddle = pend_paddle_q | ev_paddle;
        eff_score  = pend_score_q  | ev_score;
        sel_code   = CODE_NONE;
        if (eff_score) begin
            sel_code = CODE_SCORE;
        end else if (eff_paddle) begin
            sel_code = CODE_PADDLE;
        end else if (eff_wall) begin
            sel_code = CODE_WALL;
        end
    end

    assign push = (sel_code != CODE_NONE) && !game_end && !is_dup && !fifo_full;
    assign drop = (sel_code != CODE_NONE) && !game_end && !is_dup && fifo_full;
    assign pop  = (state_q == S_ISSUE) && !game_end;

    // Next-state logic for latches, FIFO, sequencer FSM and registered outputs.
    always_comb begin
        pend_wall_d   = eff_wall   && (sel_code != CODE_WALL);
        pend_paddle_d = eff_paddle && (sel_code != CODE_PADDLE);
        pend_score_d  = eff_score  && (sel_code != CODE_SCORE);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel_code;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + {4'd0, push} - {4'd0, pop};
        overflow_d = overflow_q | drop;

        state_d      = state_q;
        timer_d      = timer_q;
        tone_start_d = 1'b0;
        tone_abort_d = 1'b0;
        tone_half_d  = tone_half_q;
        tone_dur_d   = tone_dur_q;
        ack_err_d    = ack_err_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != 5'd0) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tone_start_d = 1'b1;
                tone_half_d  = half_of(head_code);
                tone_dur_d   = dur_of(head_code);
                timer_d      = '0;
                state_d      = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tone_busy) begin
                    state_d = S_PLAY;
                end else if (timer_q == ACK_TIMEOUT - 1) begin
                    ack_err_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_GAP;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_PLAY: begin
                if (!tone_busy) begin
                    timer_d = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_CYCLES - 1) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Game over overrides everything: flush, return to IDLE, abort a live tone.
        if (game_end) begin
            pend_wall_d   = 1'b0;
            pend_paddle_d = 1'b0;
            pend_score_d  = 1'b0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            state_d       = S_IDLE;
            timer_d       = '0;
            tone_start_d  = 1'b0;
            tone_half_d   = tone_half_q;
            tone_dur_d    = tone_dur_q;
            ack_err_d     = ack_err_q;
            tone_abort_d  = (state_q == S_WAIT_ACK) || (state_q == S_PLAY);
        end
    end

    // State registers; reset clears everything without pulsing tone_abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pend_wall_q   <= 1'b0;
            pend_paddle_q <= 1'b0;
            pend_score_q  <= 1'b0;
            tone_start_q  <= 1'b0;
            tone_half_q   <= '0;
            tone_dur_q    <= '0;
            tone_abort_q  <= 1'b0;
            overflow_q    <= 1'b0;
            ack_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pend_wall_q   <= pend_wall_d;
            pend_paddle_q <= pend_paddle_d;
            pend_score_q  <= pend_score_d;
            tone_start_q  <= tone_start_d;
            tone_half_q   <= tone_half_d;
            tone_dur_q    <= tone_dur_d;
            tone_abort_q  <= tone_abort_d;
            overflow_q    <= overflow_d;
            ack_err_q     <= ack_err_d;
        end
    end

    assign tone_start = tone_start_q;
    assign tone_half  = tone_half_q;
    assign tone_dur   = tone_dur_q;
    assign tone_abort = tone_abort_q;
    assign q_level    = count_q;
    assign overflow   = overflow_q;
    assign ack_err    = ack_err_q;

endmodule
